// File: rtl/enemy_walker.sv
// Walking enemy: patrols between bounds, is squashed by a stomp, vanishes after a timed squash and re-arms on spawn.
// Optional ENEMY_WALKER_CHASE_EN: on each walking tick, turn toward Mario before moving.
module enemy_walker #(
  parameter logic [9:0] X_MIN        = 10'd0,
  parameter logic [9:0] X_MAX        = 10'd639,
  parameter logic [9:0] X_ORI        = 10'd400,
  parameter logic [9:0] Y_ORI        = 10'd384,
  parameter logic [9:0] X_STEP       = 10'd2,
  parameter logic [9:0] SIZE         = 10'd32,
  parameter logic [7:0] ANIM_DIV     = 8'd8,
  parameter logic [7:0] SQUASH_TICKS = 8'd30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] process,
  input  logic [9:0] mario_x,
  input  logic       stomp,
  input  logic       spawn,
  output logic       enemy_on,
  output logic [9:0] enemy_x,
  output logic [9:0] enemy_y,
  output logic       alive,
  output logic       facing,
  output logic [1:0] anim_sel,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] WALK   = 2'd0;
  localparam logic [1:0] SQUASH = 2'd1;
  localparam logic [1:0] GONE   = 2'd2;

  logic [1:0] state;
  logic [2:0] fs;
  logic       tick;
  logic [7:0] anim_cnt;
  logic [7:0] sq_cnt;
  logic       walk_frame;

  logic       dir;
  logic [9:0] mv_x;
  logic       mv_facing;
  logic [10:0] ex11, ey11, wx11, dy11;

  // stomp and spawn are plain one-Clk pulses with no handshake; they act only in WALK and GONE respectively.
  assign tick = fs[1] & ~fs[2];

  assign ex11 = {1'b0, enemy_x};
  assign ey11 = {1'b0, enemy_y};
  assign wx11 = {1'b0, DrawX} + {1'b0, process};
  assign dy11 = {1'b0, DrawY};

  always_comb begin
    dir = facing;
`ifdef ENEMY_WALKER_CHASE_EN
    dir = ({1'b0, mario_x} < ex11) ? 1'b0 : 1'b1;
`endif
    mv_x      = enemy_x;
    mv_facing = dir;
    if (!dir) begin
      if (ex11 < ({1'b0, X_MIN} + {1'b0, X_STEP})) begin
        mv_x      = X_MIN;
        mv_facing = 1'b1;
      end else begin
        mv_x = enemy_x - X_STEP;
      end
    end else begin
      if ((ex11 + {1'b0, SIZE} + {1'b0, X_STEP}) > {1'b0, X_MAX}) begin
        mv_x      = X_MAX - SIZE;
        mv_facing = 1'b0;
      end else begin
        mv_x = enemy_x + X_STEP;
      end
    end
  end

`ifndef ENEMY_WALKER_CHASE_EN
  logic unused_mario;
  assign unused_mario = ^mario_x;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= WALK;
      fs         <= 3'b000;
      enemy_x    <= X_ORI;
      enemy_y    <= Y_ORI;
      facing     <= 1'b0;
      walk_frame <= 1'b0;
      anim_cnt   <= 8'd0;
      sq_cnt     <= 8'd0;
    end else begin
      fs <= {fs[1:0], frame_clk};
      case (state)
        WALK: begin
          // A stomp on a tick cycle suppresses that tick's move.
          if (stomp) begin
            state  <= SQUASH;
            sq_cnt <= 8'd0;
          end else if (tick) begin
            enemy_x <= mv_x;
            facing  <= mv_facing;
            if (anim_cnt == ANIM_DIV - 8'd1) begin
              anim_cnt   <= 8'd0;
              walk_frame <= ~walk_frame;
            end else begin
              anim_cnt <= anim_cnt + 8'd1;
            end
          end
        end
        SQUASH: begin
          if (tick) begin
            if (sq_cnt == SQUASH_TICKS - 8'd1) state <= GONE;
            else sq_cnt <= sq_cnt + 8'd1;
          end
        end
        GONE: begin
          if (spawn) begin
            state      <= WALK;
            enemy_x    <= X_ORI;
            enemy_y    <= Y_ORI;
            facing     <= 1'b0;
            walk_frame <= 1'b0;
            anim_cnt   <= 8'd0;
          end
        end
        default: state <= WALK;
      endcase
    end
  end

  assign alive     = (state == WALK);
  assign anim_sel  = (state == SQUASH) ? 2'd2 : {1'b0, walk_frame};
  assign state_dbg = state;

  assign enemy_on = (state != GONE) &&
                    (wx11 >= ex11) && (wx11 < ex11 + {1'b0, SIZE}) &&
                    (dy11 >= ey11) && (dy11 < ey11 + {1'b0, SIZE});

endmodule
